// File: rtl/count_uart_pkg.sv
// Shared types, constants and helpers for the count UART reporter.
// Covers the serialiser state encoding, ASCII mapping and baud divisor.
package count_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Character idx of the report for val: high nibble, low nibble, CR, LF.
    function automatic logic [7:0] msg_char(input logic [7:0] val, input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = hex_ascii(val[7:4]);
            2'd1:    c = hex_ascii(val[3:0]);
            2'd2:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/count_uart_reporter_uart_tx.sv
// 8N1 byte serialiser. ready is also high in the last STOP cycle so that a
// following byte can start back-to-back with no idle gap.
module uart_tx_byte
    import count_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_divisor
            $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_last;

    assign baud_last = (baud_cnt_q == BAUD_LAST);
    assign ready     = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last);
    assign tx        = tx_q;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
            end
            ST_START: begin
                baud_cnt_d = baud_last ? '0 : baud_cnt_q + CNT_W'(1);
                if (baud_last) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                baud_cnt_d = baud_last ? '0 : baud_cnt_q + CNT_W'(1);
                if (baud_last) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            default: begin
                baud_cnt_d = baud_last ? '0 : baud_cnt_q + CNT_W'(1);
                if (baud_last) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A new byte overrides the end of STOP so characters chain seamlessly.
        if (start && ready) begin
            state_d    = ST_START;
            baud_cnt_d = '0;
            bit_cnt_d  = 3'd0;
            shift_d    = data;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: rtl/count_uart_reporter.sv
// Reports each change of the count bus as "HH\r\n" over UART 8N1, keeping
// only the newest unsent value in a one-entry pending buffer.
module count_uart_reporter
    import count_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    logic [7:0] prev_q, prev_d;
    logic       pend_valid_q, pend_valid_d;
    logic [7:0] pend_data_q, pend_data_d;
    logic       overrun_q, overrun_d;
    logic       busy_q, busy_d;
    logic [1:0] char_idx_q, char_idx_d;
    logic [7:0] msg_q, msg_d;

    logic       change, consume, byte_done, last_char;
    logic       tx_start, tx_ready;
    logic [7:0] tx_data;
    logic [7:0] char_tbl [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_char_tbl
            assign char_tbl[gi] = msg_char(msg_q, 2'(gi));
        end
    endgenerate

    always_comb begin
        change    = (value != prev_q);
        consume   = !busy_q && pend_valid_q;
        byte_done = busy_q && tx_ready;
        last_char = (char_idx_q == 2'd3);
        tx_start  = consume || (byte_done && !last_char);
        // The first character comes straight from the pending entry being consumed.
        tx_data   = consume ? hex_ascii(pend_data_q[7:4]) : char_tbl[char_idx_q + 2'd1];

        prev_d       = value;
        pend_valid_d = pend_valid_q && !consume;
        pend_data_d  = pend_data_q;
        overrun_d    = change && pend_valid_q && !consume;
        busy_d       = busy_q;
        char_idx_d   = char_idx_q;
        msg_d        = msg_q;

        if (change) begin
            pend_valid_d = 1'b1;
            pend_data_d  = value;
        end

        if (consume) begin
            msg_d      = pend_data_q;
            char_idx_d = 2'd0;
            busy_d     = 1'b1;
        end else if (byte_done) begin
            if (last_char) begin
                busy_d = 1'b0;
            end else begin
                char_idx_d = char_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            char_idx_q   <= 2'd0;
            msg_q        <= 8'h00;
        end else begin
            prev_q       <= prev_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            char_idx_q   <= char_idx_d;
            msg_q        <= msg_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (tx_data),
        .tx   (tx),
        .ready(tx_ready)
    );

    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule
